// File: rtl/temporal_encoder_n_pkg.sv
// ---------------------------------------------------------------------------
// temporal_pkg
// Shared types and constants for the temporal (race-logic) encoder slice.
//   DEF_GAMMA_CYCLE_WIDTH : default aclk cycles per gamma cycle (power of 2)
//   DEF_PULSE_WIDTH       : default pulse length when PULSE_OUT_EN is defined
//   TVAL_W                : bits needed to hold one temporal value
//   tval_t                : one temporal value / slot counter
//   NO_SPIKE              : all-ones value, meaning "this channel never fires"
//   enc_state_t           : encoder FSM states
// ---------------------------------------------------------------------------
package temporal_pkg;

   localparam int DEF_GAMMA_CYCLE_WIDTH = 16;
   localparam int DEF_PULSE_WIDTH       = 8;

   localparam int TVAL_W = $clog2(DEF_GAMMA_CYCLE_WIDTH);

   typedef logic [TVAL_W-1:0] tval_t;

   // The largest value is reserved for "infinity"; the counter reaches it
   // only on the final slot, where the gamma cycle ends.
   localparam tval_t NO_SPIKE = '1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } enc_state_t;

endpackage

// File: rtl/temporal_encoder_n_if.sv
// ---------------------------------------------------------------------------
// temporal_encoder_n_if
// Handshake and output bundle of the temporal encoder.
//   vals_in    : packed input values, channel i at [i*W +: W]
//   vals_valid : vals_in holds a vector to encode
//   vals_ready : encoder can accept a vector this cycle
//   edges_out  : one registered temporal edge (or pulse) per channel
//   busy       : a gamma cycle is in progress
//   gamma_done : one-cycle pulse after the last slot of a gamma cycle
// Modports: master = vector producer, slave = encoder.
// ---------------------------------------------------------------------------
interface temporal_encoder_n_if #(
   parameter int NUM_INPUTS = 4,
   parameter int W          = 4
);

   logic [NUM_INPUTS*W-1:0] vals_in;
   logic                    vals_valid;
   logic                    vals_ready;
   logic [NUM_INPUTS-1:0]   edges_out;
   logic                    busy;
   logic                    gamma_done;

   modport master (
      output vals_in,
      output vals_valid,
      input  vals_ready,
      input  edges_out,
      input  busy,
      input  gamma_done
   );

   modport slave (
      input  vals_in,
      input  vals_valid,
      output vals_ready,
      output edges_out,
      output busy,
      output gamma_done
   );

endinterface

// File: rtl/temporal_encoder_n_edge_gen.sv
// ---------------------------------------------------------------------------
// temporal_edge_gen
// One temporal output channel: holds its latched value and the registered
// edge flop. All channels share the encoder's slot counter.
// Optional feature macro: PULSE_OUT_EN (edge becomes a PULSE_WIDTH pulse).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start    : vector accepted this cycle (latch val_in, clear edge)
//   run      : encoder is in a gamma cycle
//   cnt      : current slot number within the gamma cycle
//   val_in   : this channel's slice of the incoming vector
//   edge_out : registered, glitch-free temporal output
// ---------------------------------------------------------------------------
module temporal_edge_gen
   import temporal_pkg::*;
#(
   parameter int W = TVAL_W
`ifdef PULSE_OUT_EN
   ,
   parameter int PULSE_WIDTH = DEF_PULSE_WIDTH
`endif
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         run,
   input  logic [W-1:0] cnt,
   input  logic [W-1:0] val_in,
   output logic         edge_out
);

   localparam logic [W-1:0] NONE = '1;

   logic [W-1:0] val_q;
   logic         hit;

   // The value is captured only at acceptance so a producer may change
   // vals_in freely while the gamma cycle is being emitted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         val_q <= '0;
      end else if (start) begin
         val_q <= val_in;
      end
   end

   // The slot that matches the value is the firing slot; the all-ones value
   // never fires even though the counter reaches it on the final slot.
   assign hit = run && (cnt == val_q) && (val_q != NONE);

`ifdef PULSE_OUT_EN

   localparam logic [W:0] PW_EXT = (W+1)'(PULSE_WIDTH);

   logic [W:0] stop_cnt;

   // The stop slot is computed one bit wider so val+PULSE_WIDTH beyond the
   // last slot never aliases onto an earlier slot.
   assign stop_cnt = {1'b0, val_q} + PW_EXT;

   // Pulse mode: rise on the firing slot, fall PULSE_WIDTH slots later, and
   // always fall on the final slot so nothing is left high in IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         edge_out <= 1'b0;
      end else if (start) begin
         edge_out <= 1'b0;
      end else if (run && (cnt == NONE)) begin
         edge_out <= 1'b0;
      end else if (hit) begin
         edge_out <= 1'b1;
      end else if (run && ({1'b0, cnt} == stop_cnt)) begin
         edge_out <= 1'b0;
      end
   end

`else

   // Edge mode: rise on the firing slot and hold until the next vector is
   // accepted, which makes the output monotonic within a gamma cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         edge_out <= 1'b0;
      end else if (start) begin
         edge_out <= 1'b0;
      end else if (hit) begin
         edge_out <= 1'b1;
      end
   end

`endif

endmodule

// File: rtl/temporal_encoder_n.sv
// ---------------------------------------------------------------------------
// temporal_encoder_n
// Race-logic transmitter: turns a vector of binary values into per-channel
// rising edges timed within one gamma cycle. Smaller value = earlier edge;
// the all-ones value means "no spike".
// Optional feature macro: PULSE_OUT_EN (fixed-width pulses instead of held
// edges; outputs are all low between gamma cycles).
// Ports:
//   aclk : clock
//   grst : asynchronous active-high reset
//   bus  : temporal_encoder_n_if.slave (vals_in/vals_valid/vals_ready,
//          edges_out, busy, gamma_done)
// ---------------------------------------------------------------------------
module temporal_encoder_n
   import temporal_pkg::*;
#(
   parameter int NUM_INPUTS        = 4,
   parameter int GAMMA_CYCLE_WIDTH = DEF_GAMMA_CYCLE_WIDTH,
   parameter int PULSE_WIDTH       = DEF_PULSE_WIDTH
) (
   input  logic                 aclk,
   input  logic                 grst,
   temporal_encoder_n_if.slave  bus
);

   localparam int W = $clog2(GAMMA_CYCLE_WIDTH);
   localparam logic [W-1:0] LAST_CNT = W'(GAMMA_CYCLE_WIDTH - 1);

   // Reject configurations where the counter could wrap or a pulse could
   // never end inside a gamma cycle.
   if (GAMMA_CYCLE_WIDTH < 4 || (GAMMA_CYCLE_WIDTH & (GAMMA_CYCLE_WIDTH - 1)) != 0) begin : g_bad_gamma
      $error("GAMMA_CYCLE_WIDTH must be a power of 2 and at least 4");
   end
   if (PULSE_WIDTH < 1 || PULSE_WIDTH > GAMMA_CYCLE_WIDTH - 1) begin : g_bad_pulse
      $error("PULSE_WIDTH must be in 1..GAMMA_CYCLE_WIDTH-1");
   end

   enc_state_t            state;
   enc_state_t            next_state;
   logic [W-1:0]          cnt;
   logic                  start;
   logic                  run;
   logic                  last;
   logic                  gamma_done_q;
   logic [NUM_INPUTS-1:0] edges;

   // Acceptance is only possible in IDLE, where vals_ready is high, so the
   // handshake reduces to valid qualified by state.
   assign run   = (state == RUN);
   assign start = (state == IDLE) && bus.vals_valid;
   assign last  = run && (cnt == LAST_CNT);

   // State register.
   always_ff @(posedge aclk or posedge grst) begin
      if (grst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: one accepted vector buys exactly one gamma cycle, and
   // the final slot returns to IDLE so a new vector can be taken right away.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.vals_valid) next_state = RUN;
         RUN:     if (cnt == LAST_CNT) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output logic derived purely from state.
   always_comb begin
      bus.vals_ready = (state == IDLE);
      bus.busy       = (state == RUN);
   end

   // Slot counter: starts at zero on the first RUN cycle and is cleared when
   // RUN exits, so it never wraps.
   always_ff @(posedge aclk or posedge grst) begin
      if (grst) begin
         cnt <= '0;
      end else if (start || last) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= cnt + 1'b1;
      end
   end

   // gamma_done is registered from the final slot so it lands in the cycle
   // right after the gamma cycle, which is also the next acceptance cycle.
   always_ff @(posedge aclk or posedge grst) begin
      if (grst) begin
         gamma_done_q <= 1'b0;
      end else begin
         gamma_done_q <= last;
      end
   end

   assign bus.gamma_done = gamma_done_q;

   // One edge generator per channel, all slaved to the shared counter.
   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_chan
      temporal_edge_gen #(
         .W           (W)
`ifdef PULSE_OUT_EN
         ,
         .PULSE_WIDTH (PULSE_WIDTH)
`endif
      ) u_edge (
         .clk      (aclk),
         .rst      (grst),
         .start    (start),
         .run      (run),
         .cnt      (cnt),
         .val_in   (bus.vals_in[i*W +: W]),
         .edge_out (edges[i])
      );
   end

   assign bus.edges_out = edges;

endmodule

// File: tb/tb_temporal_encoder_n.sv
// ---------------------------------------------------------------------------
// tb_temporal_encoder_n
// Self-checking bench for temporal_encoder_n (edge mode by default, pulse
// mode when PULSE_OUT_EN is defined). Expected per-cycle outputs come from a
// small timing model and are queued when a vector is driven, then popped and
// compared on each falling edge.
// ---------------------------------------------------------------------------
module tb_temporal_encoder_n;

   localparam int NUM = 4;
   localparam int GCW = 16;
   localparam int W   = 4;
   localparam int PW  = 8;

   typedef struct packed {
      logic [NUM-1:0] edges;
      logic           gamma_done;
      logic           busy;
      logic           ready;
   } exp_t;

   logic aclk;
   logic grst;
   logic clk_en;
   int   checks;
   int   failures;
   exp_t sb[$];

   temporal_encoder_n_if #(.NUM_INPUTS(NUM), .W(W)) bus ();

   temporal_encoder_n #(
      .NUM_INPUTS        (NUM),
      .GAMMA_CYCLE_WIDTH (GCW),
      .PULSE_WIDTH       (PW)
   ) dut (
      .aclk (aclk),
      .grst (grst),
      .bus  (bus)
   );

   // Free-running clock that can be held low for the clockless reset check.
   initial aclk = 1'b0;
   always #5 if (clk_en) aclk = ~aclk;

   // Expected outputs d cycles after the acceptance edge (d=1 is the first
   // RUN cycle, d=17 the gamma_done cycle, later d values are idle cycles).
   function automatic exp_t model(input logic [NUM*W-1:0] vals, input int d);
      exp_t e;
      int   v;
      e.busy       = (d >= 1) && (d <= GCW);
      e.ready      = !e.busy;
      e.gamma_done = (d == GCW + 1);
      for (int i = 0; i < NUM; i++) begin
         v = int'(vals[i*W +: W]);
         if (v == GCW - 1) begin
            e.edges[i] = 1'b0;
         end else begin
`ifdef PULSE_OUT_EN
            e.edges[i] = (d >= 2 + v) && (d < 2 + v + PW) && (d <= GCW);
`else
            e.edges[i] = (d >= 2 + v);
`endif
         end
      end
      return e;
   endfunction

   task automatic push_gamma(input logic [NUM*W-1:0] vals, input int nd);
      for (int d = 1; d <= nd; d++) sb.push_back(model(vals, d));
   endtask

   function automatic logic [NUM*W-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
      return {W'(c3), W'(c2), W'(c1), W'(c0)};
   endfunction

   // Pulse grst while the clock is stopped; outputs must settle anyway.
   task automatic test_reset();
      clk_en = 1'b0;
      bus.vals_valid = 1'b0;
      bus.vals_in = '0;
      grst = 1'b0;
      #3 grst = 1'b1;
      #2 grst = 1'b0;
      #2;
      checks++;
      if (bus.vals_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_ready got=%b exp=1", bus.vals_ready);
      end
      checks++;
      if (bus.edges_out !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL reset_edges got=%b exp=0000", bus.edges_out);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy);
      end
      checks++;
      if (bus.gamma_done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_gamma_done got=%b exp=0", bus.gamma_done);
      end
      clk_en = 1'b1;
      @(negedge aclk);
   endtask

   // {0,3,7,14}: staggered edges, gamma_done timing, then idle hold.
   task automatic test_basic();
      logic [NUM*W-1:0] v;
      exp_t e;
      v = pack4(0, 3, 7, 14);
      bus.vals_in = v;
      bus.vals_valid = 1'b1;
      push_gamma(v, GCW + 3);
      for (int d = 1; d <= GCW + 3; d++) begin
         @(negedge aclk);
         if (d == 1) bus.vals_valid = 1'b0;
         e = sb.pop_front();
         checks++;
         if ({bus.edges_out, bus.gamma_done, bus.busy, bus.vals_ready} !== e) begin
            failures++;
            $display("[TB] FAIL basic d=%0d edges=%b exp=%b gd=%b exp=%b busy=%b exp=%b ready=%b exp=%b",
                     d, bus.edges_out, e.edges, bus.gamma_done, e.gamma_done, bus.busy, e.busy, bus.vals_ready, e.ready);
         end
      end
   endtask

   // {5,15,5,5}: tied channels rise together, NO_SPIKE channel never rises.
   task automatic test_nospike_ties();
      logic [NUM*W-1:0] v;
      exp_t e;
      v = pack4(5, 15, 5, 5);
      bus.vals_in = v;
      bus.vals_valid = 1'b1;
      push_gamma(v, GCW + 1);
      for (int d = 1; d <= GCW + 1; d++) begin
         @(negedge aclk);
         if (d == 1) bus.vals_valid = 1'b0;
         e = sb.pop_front();
         checks++;
         if ({bus.edges_out, bus.gamma_done, bus.busy, bus.vals_ready} !== e) begin
            failures++;
            $display("[TB] FAIL nospike_ties d=%0d edges=%b exp=%b gd=%b exp=%b busy=%b exp=%b ready=%b exp=%b",
                     d, bus.edges_out, e.edges, bus.gamma_done, e.gamma_done, bus.busy, e.busy, bus.vals_ready, e.ready);
         end
         checks++;
         if (bus.edges_out[1] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nospike_ch1 d=%0d got=%b exp=0", d, bus.edges_out[1]);
         end
      end
   endtask

   // A new vector held valid during RUN is ignored until the gamma_done
   // cycle, where it is accepted back to back.
   task automatic test_handshake();
      logic [NUM*W-1:0] v1;
      logic [NUM*W-1:0] v2;
      exp_t e;
      v1 = pack4(0, 3, 7, 14);
      v2 = pack4(2, 2, 9, 1);
      bus.vals_in = v1;
      bus.vals_valid = 1'b1;
      push_gamma(v1, GCW + 1);
      push_gamma(v2, GCW + 1);
      for (int j = 1; j <= 2 * (GCW + 1); j++) begin
         @(negedge aclk);
         if (j == 1) bus.vals_in = v2;
         if (j == GCW + 2) bus.vals_valid = 1'b0;
         e = sb.pop_front();
         checks++;
         if ({bus.edges_out, bus.gamma_done, bus.busy, bus.vals_ready} !== e) begin
            failures++;
            $display("[TB] FAIL handshake j=%0d edges=%b exp=%b gd=%b exp=%b busy=%b exp=%b ready=%b exp=%b",
                     j, bus.edges_out, e.edges, bus.gamma_done, e.gamma_done, bus.busy, e.busy, bus.vals_ready, e.ready);
         end
      end
   endtask

   // Ch0 sweeps 0..14 with back-to-back vectors; rise time and rise count.
   task automatic test_sweep();
      logic [NUM*W-1:0] v;
      exp_t e;
      logic prev;
      int   rises;
      int   rise_d;
      for (int val = 0; val < GCW - 1; val++) begin
         v = pack4(val, 15, 15, 15);
         bus.vals_in = v;
         bus.vals_valid = 1'b1;
         push_gamma(v, GCW + 1);
         prev = 1'b0;
         rises = 0;
         rise_d = -1;
         for (int d = 1; d <= GCW + 1; d++) begin
            @(negedge aclk);
            if (d == 1) bus.vals_valid = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({bus.edges_out, bus.gamma_done, bus.busy, bus.vals_ready} !== e) begin
               failures++;
               $display("[TB] FAIL sweep v=%0d d=%0d edges=%b exp=%b gd=%b exp=%b busy=%b exp=%b",
                        val, d, bus.edges_out, e.edges, bus.gamma_done, e.gamma_done, bus.busy, e.busy);
            end
            if (d > 1 && bus.edges_out[0] === 1'b1 && prev === 1'b0) begin
               rises++;
               rise_d = d;
            end
            prev = bus.edges_out[0];
         end
         checks++;
         if (rises != 1) begin
            failures++;
            $display("[TB] FAIL sweep_rise_count v=%0d got=%0d exp=1", val, rises);
         end
         checks++;
         if (rise_d != 2 + val) begin
            failures++;
            $display("[TB] FAIL sweep_rise_time v=%0d got=k+%0d exp=k+%0d", val, rise_d, 2 + val);
         end
      end
   endtask

   // grst while cnt==6: outputs clear without a clock and no gamma_done follows.
   task automatic test_midrun_reset();
      logic [NUM*W-1:0] v;
      exp_t e;
      v = pack4(0, 3, 7, 14);
      bus.vals_in = v;
      bus.vals_valid = 1'b1;
      push_gamma(v, 7);
      for (int d = 1; d <= 7; d++) begin
         @(negedge aclk);
         if (d == 1) bus.vals_valid = 1'b0;
         e = sb.pop_front();
         checks++;
         if ({bus.edges_out, bus.gamma_done, bus.busy, bus.vals_ready} !== e) begin
            failures++;
            $display("[TB] FAIL midrun_pre d=%0d edges=%b exp=%b busy=%b exp=%b",
                     d, bus.edges_out, e.edges, bus.busy, e.busy);
         end
      end
      checks++;
      if (bus.edges_out !== 4'b0011) begin
         failures++;
         $display("[TB] FAIL midrun_before got=%b exp=0011", bus.edges_out);
      end
      #1 grst = 1'b1;
      #1;
      checks++;
      if (bus.edges_out !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL midrun_edges got=%b exp=0000", bus.edges_out);
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.vals_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL midrun_state busy=%b exp=0 ready=%b exp=1", bus.busy, bus.vals_ready);
      end
      #1 grst = 1'b0;
      sb.delete();
      for (int c = 0; c < 20; c++) begin
         @(negedge aclk);
         checks++;
         if (bus.gamma_done !== 1'b0 || bus.busy !== 1'b0 || bus.edges_out !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL midrun_after c=%0d gd=%b exp=0 busy=%b exp=0 edges=%b exp=0000",
                     c, bus.gamma_done, bus.busy, bus.edges_out);
         end
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_basic();
      test_nospike_ties();
      test_handshake();
      test_sweep();
      test_midrun_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/temporal_encoder_n.md
Name: temporal_encoder_N

Overview:
- Transmitter side of the temporal (race-logic) interface: converts a vector of binary values into per-channel rising-edge transitions timed within one gamma cycle of aclk.
- Feeds temporal consumers such as mux_t_t_t_N and column logic, which read information from edge arrival time.
- A smaller value produces an earlier edge. The all-ones value means "no spike" (infinity).

Parameters:
- NUM_INPUTS, 4, number of temporal output channels.
- GAMMA_CYCLE_WIDTH, 16, aclk cycles per gamma cycle; must be a power of 2 and at least 4.
- PULSE_WIDTH, 8, pulse length in aclk cycles; used only with PULSE_OUT_EN; range 1..GAMMA_CYCLE_WIDTH-1.

Ports:
- aclk  input  1  clock.
- grst  input  1  asynchronous active-high reset.
- vals_in  input  NUM_INPUTS*W  packed values; W = $clog2(GAMMA_CYCLE_WIDTH); channel i is at [i*W +: W].
- vals_valid  input  1  vals_in is valid.
- vals_ready  output  1  encoder can accept a vector.
- edges_out  output  NUM_INPUTS  temporal edge outputs, glitch-free (registered).
- busy  output  1  gamma cycle in progress.
- gamma_done  output  1  one-cycle pulse after the last gamma cycle slot.

Behaviour:
- Reset (grst high, asynchronous): state=IDLE, cnt=0, vals_ready=1, edges_out=0, busy=0, gamma_done=0, value registers=0.
- FSM states: IDLE, RUN.
- IDLE:
  - vals_ready=1.
  - When vals_valid&&vals_ready at a clock edge: latch vals_in, clear edges_out, set cnt=0, go to RUN.
- RUN:
  - vals_ready=0; vals_valid is ignored, with no latching and no error.
  - cnt increments by 1 each aclk.
  - At cnt==GAMMA_CYCLE_WIDTH-1: go to IDLE, cnt=0, and register gamma_done=1 for exactly one cycle.
- busy=(state==RUN).
- Edge rule:
  - In a RUN cycle where cnt==val[i] and val[i]!=NO_SPIKE, edges_out[i] is set at that clock edge.
  - NO_SPIKE = all-ones = GAMMA_CYCLE_WIDTH-1, so such a channel never rises.
  - Edges stay high, including through IDLE, until the next vector is accepted.
- Latency: if the vector is accepted at the end of cycle k:
  - First RUN cycle is k+1 (cnt=0).
  - edges_out[i] is high from cycle k+2+val[i].
  - gamma_done is high in cycle k+1+GAMMA_CYCLE_WIDTH.
  - Back-to-back acceptance is possible in that same cycle.
- Relative edge spacing equals the value difference exactly.
- Channels with equal values rise in the same cycle.
- Edges are monotonic: no 1→0 transition during RUN in edge mode.
- cnt is W bits wide; wrap-around never occurs because RUN exits at the maximum count.
- grst mid-RUN: all outputs clear immediately without a clock; a partially emitted gamma cycle is discarded.

Optional Feature:
- Macro: PULSE_OUT_EN.
- Defined:
  - edges_out[i] goes high on the same cycle as the edge rule and stays high exactly PULSE_WIDTH cycles.
  - It is cleared at the edge where cnt==val[i]+PULSE_WIDTH, compared at W+1-bit width.
  - A pulse is truncated when RUN exits, so all edges_out are 0 in IDLE.
  - A NO_SPIKE channel never pulses.
- Undefined: edge-mode behaviour as above.

Decomposition:
- Package temporal_pkg holds:
  - GAMMA_CYCLE_WIDTH and PULSE_WIDTH defaults.
  - localparam TVAL_W.
  - typedef tval_t logic[TVAL_W-1:0].
  - constant NO_SPIKE.
  - enum enc_state_t {IDLE, RUN}.
- Sub-module temporal_edge_gen: one channel holding its value register and edge/pulse flop. It is driven by shared cnt, start, and run signals and instantiated NUM_INPUTS times via generate.

Test Plan:
- Reset: pulse grst with no clock -> vals_ready=1, edges_out=4'b0000, busy=0, gamma_done=0.
- Accept {ch0=0, ch1=3, ch2=7, ch3=14} at cycle k -> edges_out[0] rises at k+2, [1] at k+5, [2] at k+9, [3] at k+16; gamma_done is high only in k+17; edges are held at 4'b1111 until the next accept.
  - With PULSE_OUT_EN: each channel is high for 8 cycles; ch3 (14) is truncated to 1 cycle.
- NO_SPIKE and ties: vals {5,15,5,5} -> ch0, ch2 and ch3 rise together at k+7; ch1 stays 0 for the whole gamma cycle.
- Handshake: hold vals_valid high with a new vector during RUN -> vals_ready=0 and the vector is ignored. It is accepted in the gamma_done cycle; edges_out clears in the next cycle and the new timing starts.
- Mid-run reset: assert grst while cnt==6 after {0,3,7,14} -> edges_out falls from 4'b0011 to 0 asynchronously, busy=0, and no gamma_done pulse follows.
- Sweep: for each v in 0..14 on ch0 -> rise occurs exactly at k+2+v and never rises twice.
